// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter with burst lock feeding one registered valid/ready stage; 1-cycle latency.
// Back-pressure: a held output beat (o_valid & ~i_ready) deasserts every o_ready and freezes all outputs.
module pipeline_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int VALUE_BITS = 8,
  parameter int ID_BITS    = $clog2(CHANNELS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS*VALUE_BITS-1:0] i_value,
  input  logic [CHANNELS-1:0]            i_valid,
  input  logic [CHANNELS-1:0]            i_last,
  output logic [CHANNELS-1:0]            o_ready,
  output logic [VALUE_BITS-1:0]          o_value,
  output logic [ID_BITS-1:0]             o_id,
  output logic                           o_last,
  output logic                           o_valid,
  input  logic                           i_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [VALUE_BITS-1:0] value;
    logic [ID_BITS-1:0]    id;
    logic                  last;
  } beat_t;

  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(CHANNELS - 1);

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   r_ptr, ptr_d;
  logic [ID_BITS-1:0]   r_owner, owner_d;
  logic [ID_BITS-1:0]   sel;
  logic                 sel_vld;
  logic                 ld;
  logic                 xfer;
  int                   cand;
  beat_t                beat_q, beat_d;

  assign ld = ~o_valid | i_ready;

  // Scan from the highest offset down so the channel nearest r_ptr is written last and wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = 0;
    if (state_q == LOCKED) begin
      sel     = r_owner;
      sel_vld = i_valid[r_owner];
    end else begin
      for (int d = CHANNELS - 1; d >= 0; d--) begin
        cand = int'(r_ptr) + d;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        if (i_valid[ID_BITS'(cand)]) begin
          sel     = ID_BITS'(cand);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign xfer = ld & sel_vld & ~reset;

  always_comb begin
    o_ready = '0;
    if (xfer) o_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = r_ptr;
    owner_d = r_owner;
    beat_d  = beat_q;
    if (xfer) begin
      beat_d.value = i_value[sel*VALUE_BITS +: VALUE_BITS];
      beat_d.id    = sel;
      beat_d.last  = i_last[sel];
      if (i_last[sel]) begin
        state_d = IDLE;
        ptr_d   = (sel == LAST_ID) ? '0 : sel + ID_BITS'(1);
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      state_q <= state_d;
      r_ptr   <= ptr_d;
      r_owner <= owner_d;
    end
  end

  // Payload only moves on a transfer; o_valid follows ld so bubbles drain the stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q  <= '0;
      o_valid <= 1'b0;
    end else if (ld) begin
      beat_q  <= beat_d;
      o_valid <= xfer;
    end
  end

  assign o_value = beat_q.value;
  assign o_id    = beat_q.id;
  assign o_last  = beat_q.last;

endmodule
